// File: rtl/nor4_response_checker.sv
// nor4_response_checker
//
// Checks the responses of an external 4-input NOR gate. A run is started
// with a one-cycle start request; every qualified sample during the run has
// its response compared against the NOR of the applied stimulus. The block
// counts mismatches, records which stimulus values were exercised, and
// captures the stimulus of the first mismatch. After NUM_SAMPLES accepted
// samples the run finishes and the verdict is held until the next start.
//
// Ports
//   clk              : clock, all state changes on the rising edge
//   rst_n            : synchronous active-low reset
//   start            : one-cycle request to begin a run (IDLE/DONE only)
//   sample_valid     : qualifies stim and dut_out (RUN only)
//   stim             : applied stimulus {d,c,b,a}
//   dut_out          : observed NOR response to stim
//   busy             : high while a run is in progress
//   done             : high once a run has finished
//   pass             : high in DONE when the run saw no mismatches
//   err_cnt          : mismatch count of the current or last run (saturating)
//   first_fail_vec   : stim of the first mismatching sample
//   first_fail_valid : high once first_fail_vec holds a capture
//   coverage         : bit k set once stim==k has been sampled in this run

module nor4_response_checker #(
   parameter int NUM_SAMPLES = 16,
   parameter int CNT_W       = 8
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic             sample_valid,
   input  logic [3:0]       stim,
   input  logic             dut_out,
   output logic             busy,
   output logic             done,
   output logic             pass,
   output logic [CNT_W-1:0] err_cnt,
   output logic [3:0]       first_fail_vec,
   output logic             first_fail_valid,
   output logic [15:0]      coverage
);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_t;

   // Count value held just before the final sample of a run is accepted.
   localparam logic [CNT_W-1:0] LastCount = CNT_W'(NUM_SAMPLES - 1);
   localparam logic [CNT_W-1:0] ErrMax    = {CNT_W{1'b1}};

   state_t           state_q,     state_d;
   logic [CNT_W-1:0] sampleCnt_q, sampleCnt_d;
   logic [CNT_W-1:0] errCnt_q,    errCnt_d;
   logic [15:0]      cov_q,       cov_d;
   logic [3:0]       ffVec_q,     ffVec_d;
   logic             ffValid_q,   ffValid_d;
   logic             pass_q,      pass_d;
   logic             busy_q,      busy_d;
   logic             done_q,      done_d;

   logic expectedOut;
   logic mismatch;

   // Next-state logic. Status flags are derived from the next state so that
   // every output comes straight from a flop and changes on the same edge
   // as the state itself.
   always_comb begin
      state_d     = state_q;
      sampleCnt_d = sampleCnt_q;
      errCnt_d    = errCnt_q;
      cov_d       = cov_q;
      ffVec_d     = ffVec_q;
      ffValid_d   = ffValid_q;
      expectedOut = ~(|stim);
      mismatch    = dut_out ^ expectedOut;

      case (state_q)
         IDLE, DONE: begin
            if (start) begin
               state_d     = RUN;
               sampleCnt_d = '0;
               errCnt_d    = '0;
               cov_d       = '0;
               ffVec_d     = '0;
               ffValid_d   = 1'b0;
            end
         end
         RUN: begin
            if (sample_valid) begin
               cov_d[stim] = 1'b1;
               sampleCnt_d = sampleCnt_q + 1'b1;
               if (mismatch) begin
                  if (errCnt_q != ErrMax) begin
                     errCnt_d = errCnt_q + 1'b1;
                  end
                  if (!ffValid_q) begin
                     ffVec_d   = stim;
                     ffValid_d = 1'b1;
                  end
               end
               // The final sample is fully counted above and the run
               // finishes on this same edge.
               if (sampleCnt_q == LastCount) begin
                  state_d = DONE;
               end
            end
         end
         default: begin
            state_d = IDLE;
         end
      endcase

      busy_d = (state_d == RUN);
      done_d = (state_d == DONE);
      pass_d = (state_d == DONE) && (errCnt_d == '0);
   end

   // State register with synchronous reset.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q     <= IDLE;
         sampleCnt_q <= '0;
         errCnt_q    <= '0;
         cov_q       <= '0;
         ffVec_q     <= '0;
         ffValid_q   <= 1'b0;
         pass_q      <= 1'b0;
         busy_q      <= 1'b0;
         done_q      <= 1'b0;
      end else begin
         state_q     <= state_d;
         sampleCnt_q <= sampleCnt_d;
         errCnt_q    <= errCnt_d;
         cov_q       <= cov_d;
         ffVec_q     <= ffVec_d;
         ffValid_q   <= ffValid_d;
         pass_q      <= pass_d;
         busy_q      <= busy_d;
         done_q      <= done_d;
      end
   end

   assign busy             = busy_q;
   assign done             = done_q;
   assign pass             = pass_q;
   assign err_cnt          = errCnt_q;
   assign first_fail_vec   = ffVec_q;
   assign first_fail_valid = ffValid_q;
   assign coverage         = cov_q;

endmodule
